mixed_drive_vec_checker: RTL and testbench
==========================================

Name: mixed_drive_vec_checker

Overview:
- Self-checking split-driven vector block and the parametrised successor of the two-bit mixed-assignment checker.
- A free-running cycle counter drives the low COMB_BITS bits of a packed vector combinationally; the upper bits are clocked registers.
- An independently built shadow copy is compared against the expected pattern every active cycle, with error counting and first-failure capture.
- Used as a regression block for mixed continuous/nonblocking drivers on one packed variable, and as a lightweight on-chip invariant monitor.

Parameters:
- WIDTH, 2, total vector width; legal range 2..32.
- COMB_BITS, 1, number of low bits driven combinationally; legal range 1..WIDTH-1.
- MODE, 0, upper-bit rule. 0 = toggle each active cycle. 1 = registered copy of the counter.
- CYC_W, 32, counter width; must be >= WIDTH-COMB_BITS and >= COMB_BITS.
- LIMIT, 99, counter value at which the run completes; must be < 2**CYC_W.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  advance enable; ignored once done_o=1.
- inj_valid  in  1  fault injection strobe.
- inj_bit  in  $clog2(WIDTH)  shadow bit to corrupt while inj_valid=1.
- vec_o  out  WIDTH  primary split-driven vector.
- shadow_o  out  WIDTH  shadow vector, after injection.
- cyc_o  out  CYC_W  current counter value.
- err_o  out  1  sticky mismatch flag.
- err_cnt_o  out  8  saturating mismatch count.
- first_err_cyc_o  out  CYC_W  cyc_o value at the first mismatch.
- done_o  out  1  run complete.

Behaviour:
- Reset (asynchronous, rst_n=0) clears everything: cyc, all registered vector bits, shadow registers, err_o, err_cnt_o, first_err_cyc_o and done_o.
- Active cycle: a rising edge with en=1 and done_o=0. All state holds on non-active edges.
- Counter: cyc <= cyc+1 on each active cycle. No wrap is reachable, because the run stops at LIMIT.
- vec_o[i] for i < COMB_BITS: equals cyc[i] combinationally, with zero latency.
- vec_o[i] for i >= COMB_BITS is a register, written only on active edges:
  - MODE 0: vec[i] <= ~vec[i]. Invariant: vec[i] == cyc[0].
  - MODE 1: vec[i] <= (cyc+1)[i-COMB_BITS]. Invariant: vec[i] == cyc[i-COMB_BITS].
- Shadow path:
  - Separate register shcyc is updated identically to cyc.
  - Shadow comb bits come from shcyc.
  - Shadow upper bits are separate per-bit registers following the same MODE rule.
  - shadow_o = raw_shadow XOR (inj_valid ? 1<<inj_bit : 0). The XOR is combinational.
  - An inj_bit >= WIDTH has no effect.
- Expected pattern exp[i] = cyc[i] for i < COMB_BITS; for i >= COMB_BITS, MODE 0 gives cyc[0] and MODE 1 gives cyc[i-COMB_BITS].
- Check, on each active edge, using pre-edge values:
  - mismatch = (vec_o != exp) OR (shadow_o != exp).
  - One mismatch cycle increments err_cnt_o by exactly 1, saturating at 255.
  - A mismatch sets err_o.
  - On the first mismatch only (err_o was 0), first_err_cyc_o <= cyc.
  - The check and the counter increment occur on the same edge.
- Completion:
  - The edge on which cyc becomes LIMIT also sets done_o.
  - With done_o=1 the block freezes: no increment, no checks, no error updates; injection affects shadow_o only.
  - done_o stays high until reset.
- Simultaneous events:
  - A mismatch on the completion edge is counted.
  - Injection with en=0 is not counted.
  - Reset during a run aborts it immediately and clears everything, including errors.

Test Plan:
- Reset: rst_n=0 mid-run at cyc=37, asynchronously, no clock edge -> all outputs 0 immediately; after release, the first active edge gives cyc_o=1.
- Default run (WIDTH=2, COMB_BITS=1, MODE=0, en=1), clock from reset:
  - vec_o follows 00,11,00,11...; at cyc_o=3, vec_o=2'b11.
  - done_o=1 when cyc_o=99, then cyc_o holds 99.
  - err_cnt_o=0 throughout.
- MODE=1, WIDTH=8, COMB_BITS=3 -> at cyc_o=5, vec_o=8'h2D; at cyc_o=9, vec_o=8'h49; shadow_o equals vec_o; no errors.
- Injection: inj_valid=1 with inj_bit=0 for exactly the active cycle at cyc_o=10, then inj_valid=1 with inj_bit=1 at cyc_o=20 -> err_cnt_o=2, err_o=1, first_err_cyc_o=10.
- Freeze: en=0 for 5 edges at cyc_o=40 while inj_valid=1 -> cyc_o stays 40, vec_o is unchanged, err_cnt_o is unchanged.
- Saturation (LIMIT=400): inj_valid held high for 300 active cycles -> err_cnt_o=255 and holds, first_err_cyc_o is the first injected cycle.

Source files
------------

// File: rtl/mixed_drive_vec_checker.sv
// mixed_drive_vec_checker: split comb/registered vector + shadow self-check.
// Ports: clk, rst_n (async low), en, inj_valid, inj_bit in;
//   vec_o, shadow_o, cyc_o, err_o, err_cnt_o, first_err_cyc_o, done_o out.
module mixed_drive_vec_checker #(
  parameter int     WIDTH     = 2,
  parameter int     COMB_BITS = 1,
  parameter int     MODE      = 0,
  parameter int     CYC_W     = 32,
  parameter longint LIMIT     = 99,
  localparam int    IB_W      = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             inj_valid,
  input  logic [IB_W-1:0]  inj_bit,
  output logic [WIDTH-1:0] vec_o,
  output logic [WIDTH-1:0] shadow_o,
  output logic [CYC_W-1:0] cyc_o,
  output logic             err_o,
  output logic [7:0]       err_cnt_o,
  output logic [CYC_W-1:0] first_err_cyc_o,
  output logic             done_o
);

  localparam int UP_W = WIDTH - COMB_BITS;
  localparam logic [CYC_W-1:0] LIM = CYC_W'(LIMIT);
  localparam logic [CYC_W-1:0] ONE = CYC_W'(1);

  logic [CYC_W-1:0] r_cyc;
  logic [CYC_W-1:0] r_shcyc;
  logic [CYC_W-1:0] r_first;
  logic [UP_W-1:0]  r_up;
  logic [UP_W-1:0]  r_shup;
  logic             r_err;
  logic [7:0]       r_cnt;
  logic             r_done;

  logic [CYC_W-1:0] w_cyc_nxt;
  logic [CYC_W-1:0] w_shcyc_nxt;
  logic [UP_W-1:0]  w_up_nxt;
  logic [UP_W-1:0]  w_shup_nxt;
  logic [UP_W-1:0]  w_exp_up;
  logic [WIDTH-1:0] w_vec;
  logic [WIDTH-1:0] w_raw_sh;
  logic [WIDTH-1:0] w_inj;
  logic [WIDTH-1:0] w_shadow;
  logic [WIDTH-1:0] w_exp;
  logic             w_act;
  logic             w_mis;

  assign w_act       = en & ~r_done;
  assign w_cyc_nxt   = r_cyc + ONE;
  assign w_shcyc_nxt = r_shcyc + ONE;

  // Upper-bit rule, built separately for primary and shadow paths
  // so a fault in one path cannot hide in the other.
  if (MODE == 0) begin : g_tog
    assign w_up_nxt   = ~r_up;
    assign w_shup_nxt = ~r_shup;
    assign w_exp_up   = {UP_W{r_cyc[0]}};
  end else begin : g_cpy
    assign w_up_nxt   = w_cyc_nxt[UP_W-1:0];
    assign w_shup_nxt = w_shcyc_nxt[UP_W-1:0];
    assign w_exp_up   = r_cyc[UP_W-1:0];
  end

  assign w_vec    = {r_up, r_cyc[COMB_BITS-1:0]};
  assign w_raw_sh = {r_shup, r_shcyc[COMB_BITS-1:0]};
  assign w_exp    = {w_exp_up, r_cyc[COMB_BITS-1:0]};

  // Out-of-range inj_bit matches no index, so the mask stays zero.
  always_comb begin
    w_inj = '0;
    if (inj_valid) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (inj_bit == IB_W'(i)) w_inj[i] = 1'b1;
      end
    end
  end

  assign w_shadow = w_raw_sh ^ w_inj;
  assign w_mis    = (w_vec != w_exp) | (w_shadow != w_exp);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cyc <= '0;
      r_up  <= '0;
    end else if (w_act) begin
      r_cyc <= w_cyc_nxt;
      r_up  <= w_up_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shcyc <= '0;
    end else if (w_act) begin
      r_shcyc <= w_shcyc_nxt;
    end
  end

  for (genvar j = 0; j < UP_W; j++) begin : g_sh
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_shup[j] <= 1'b0;
      end else if (w_act) begin
        r_shup[j] <= w_shup_nxt[j];
      end
    end
  end

  // Checks use pre-edge state; the count saturates at 255.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err   <= 1'b0;
      r_cnt   <= '0;
      r_first <= '0;
    end else if (w_act && w_mis) begin
      r_err <= 1'b1;
      if (r_cnt != 8'hFF) r_cnt <= r_cnt + 8'd1;
      if (!r_err) r_first <= r_cyc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_done <= 1'b0;
    end else if (w_act && (w_cyc_nxt == LIM)) begin
      r_done <= 1'b1;
    end
  end

  assign vec_o           = w_vec;
  assign shadow_o        = w_shadow;
  assign cyc_o           = r_cyc;
  assign err_o           = r_err;
  assign err_cnt_o       = r_cnt;
  assign first_err_cyc_o = r_first;
  assign done_o          = r_done;

endmodule

// File: tb/tb_mixed_drive_vec_checker.sv
// tb_mixed_drive_vec_checker: table, directed and random checks
// of two configurations against a behavioural model.
module tb_mixed_drive_vec_checker;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        en0 = 0, iv0 = 0;
  logic [0:0]  ib0 = '0;
  logic [1:0]  vec0, sh0;
  logic [31:0] cyc0, first0;
  logic        err0, done0;
  logic [7:0]  cnt0;

  logic        en1 = 0, iv1 = 0;
  logic [2:0]  ib1 = '0;
  logic [7:0]  vec1, sh1;
  logic [31:0] cyc1, first1;
  logic        err1, done1;
  logic [7:0]  cnt1;

  mixed_drive_vec_checker u0 (
    .clk(clk), .rst_n(rst_n), .en(en0), .inj_valid(iv0), .inj_bit(ib0),
    .vec_o(vec0), .shadow_o(sh0), .cyc_o(cyc0), .err_o(err0),
    .err_cnt_o(cnt0), .first_err_cyc_o(first0), .done_o(done0));

  mixed_drive_vec_checker #(
    .WIDTH(8), .COMB_BITS(3), .MODE(1), .CYC_W(32), .LIMIT(400)
  ) u1 (
    .clk(clk), .rst_n(rst_n), .en(en1), .inj_valid(iv1), .inj_bit(ib1),
    .vec_o(vec1), .shadow_o(sh1), .cyc_o(cyc1), .err_o(err1),
    .err_cnt_o(cnt1), .first_err_cyc_o(first1), .done_o(done1));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Behavioural model: counter, error tally, first error, done.
  longint m_cyc[2];
  int     m_cnt[2];
  bit     m_err[2];
  longint m_first[2];
  bit     m_done[2];

  always @(posedge clk or negedge rst_n) begin : model
    bit e, v;
    int b, w;
    longint lim;
    if (!rst_n) begin
      for (int d = 0; d < 2; d++) begin
        m_cyc[d] = 0; m_cnt[d] = 0; m_err[d] = 0;
        m_first[d] = 0; m_done[d] = 0;
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        e   = (d == 1) ? en1 : en0;
        v   = (d == 1) ? iv1 : iv0;
        b   = (d == 1) ? int'(ib1) : int'(ib0);
        w   = (d == 1) ? 8 : 2;
        lim = (d == 1) ? 400 : 99;
        if (e && !m_done[d]) begin
          if (v && b < w) begin
            if (m_cnt[d] < 255) m_cnt[d]++;
            if (!m_err[d]) m_first[d] = m_cyc[d];
            m_err[d] = 1;
          end
          m_cyc[d]++;
          if (m_cyc[d] == lim) m_done[d] = 1;
        end
      end
    end
  end

  // Expected vector from the counter value alone.
  function automatic longint mvec(input longint c, input int w,
                                  input int cb, input int mode);
    longint lo, all, up;
    lo  = c & ((64'd1 << cb) - 1);
    all = (64'd1 << w) - 1;
    if (mode == 0) up = c[0] ? (all & ~((64'd1 << cb) - 1)) : 0;
    else           up = (c << cb) & all;
    return (up | lo) & all;
  endfunction

  task automatic cmp_all(input int d);
    longint mv, mask;
    if (d == 0) begin
      mv   = mvec(m_cyc[0], 2, 1, 0);
      mask = iv0 ? (64'd1 << ib0) : 0;
      chk("r0_vec", vec0, mv);
      chk("r0_shadow", sh0, (mv ^ mask) & 3);
      chk("r0_cyc", cyc0, m_cyc[0]);
      chk("r0_cnt", cnt0, m_cnt[0]);
      chk("r0_err", err0, m_err[0]);
      chk("r0_first", first0, m_first[0]);
      chk("r0_done", done0, m_done[0]);
    end else begin
      mv   = mvec(m_cyc[1], 8, 3, 1);
      mask = iv1 ? (64'd1 << ib1) : 0;
      chk("r1_vec", vec1, mv);
      chk("r1_shadow", sh1, (mv ^ mask) & 255);
      chk("r1_cyc", cyc1, m_cyc[1]);
      chk("r1_cnt", cnt1, m_cnt[1]);
      chk("r1_err", err1, m_err[1]);
      chk("r1_first", first1, m_first[1]);
      chk("r1_done", done1, m_done[1]);
    end
  endtask

  // Called at a negedge; advances one DUT until its counter hits tgt.
  task automatic run_to(input bit sel, input longint tgt);
    bit ok;
    longint cur;
    ok = 0;
    cur = 0;
    for (int k = 0; k < 2000; k++) begin
      cur = sel ? longint'(cyc1) : longint'(cyc0);
      if (cur == tgt) begin
        ok = 1;
        break;
      end
      if (sel) en1 = 1; else en0 = 1;
      @(negedge clk);
    end
    en0 = 0;
    en1 = 0;
    if (!ok) chk("run_to_timeout", cur, tgt);
  endtask

  typedef struct {
    bit          sel;
    longint      tgt;
    logic [7:0]  vec;
  } vec_t;

  vec_t tbl[5];
  logic [7:0] v_save;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{0, 3,  8'h03};
    tbl[1] = '{1, 5,  8'h2D};
    tbl[2] = '{1, 9,  8'h49};
    tbl[3] = '{0, 4,  8'h00};
    tbl[4] = '{0, 99, 8'h03};

    repeat (3) @(negedge clk);
    chk("rst_vec0", vec0, 0);
    chk("rst_cyc1", cyc1, 0);
    chk("rst_done1", done1, 0);
    rst_n = 1;
    @(negedge clk);

    foreach (tbl[i]) begin
      run_to(tbl[i].sel, tbl[i].tgt);
      if (tbl[i].sel) begin
        chk("tbl_vec1", vec1, tbl[i].vec);
        chk("tbl_sh1", sh1, tbl[i].vec);
        chk("tbl_cnt1", cnt1, 0);
      end else begin
        chk("tbl_vec0", vec0, tbl[i].vec);
        chk("tbl_sh0", sh0, tbl[i].vec);
        chk("tbl_cnt0", cnt0, 0);
      end
    end
    chk("done0_at_limit", done0, 1);
    en0 = 1;
    repeat (5) @(negedge clk);
    en0 = 0;
    chk("done0_hold_cyc", cyc0, 99);
    chk("done0_hold", done0, 1);

    // Injection at cyc 10 and 20.
    run_to(1, 10);
    iv1 = 1; ib1 = 0; en1 = 1;
    @(negedge clk);
    iv1 = 0; en1 = 0;
    chk("inj1_cnt", cnt1, 1);
    run_to(1, 20);
    iv1 = 1; ib1 = 1; en1 = 1;
    @(negedge clk);
    iv1 = 0; en1 = 0;
    chk("inj_cnt", cnt1, 2);
    chk("inj_err", err1, 1);
    chk("inj_first", first1, 10);

    // Freeze with injection held while en=0.
    run_to(1, 40);
    v_save = vec1;
    iv1 = 1; ib1 = 2;
    repeat (5) @(negedge clk);
    chk("frz_cyc", cyc1, 40);
    chk("frz_vec", vec1, v_save);
    chk("frz_cnt", cnt1, 2);
    chk("frz_shadow", sh1, v_save ^ 8'h04);
    iv1 = 0;

    // Asynchronous reset mid-run.
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    run_to(1, 37);
    en1 = 1;
    #2 rst_n = 0;
    #1;
    chk("arst_cyc", cyc1, 0);
    chk("arst_vec", vec1, 0);
    chk("arst_sh", sh1, 0);
    chk("arst_err", err1, 0);
    chk("arst_cnt", cnt1, 0);
    chk("arst_first", first1, 0);
    chk("arst_done", done1, 0);
    en1 = 0;
    @(negedge clk);
    rst_n = 1;
    en1 = 1;
    @(negedge clk);
    en1 = 0;
    chk("arst_first_edge", cyc1, 1);

    // Randomized run against the model.
    for (int n = 0; n < 160; n++) begin
      cmp_all(0);
      cmp_all(1);
      en0 = ($urandom_range(0, 3) != 0);
      iv0 = ($urandom_range(0, 7) == 0);
      ib0 = 1'($urandom_range(0, 1));
      en1 = ($urandom_range(0, 3) != 0);
      iv1 = ($urandom_range(0, 7) == 0);
      ib1 = 3'($urandom_range(0, 7));
      @(negedge clk);
    end
    en0 = 0; iv0 = 0; en1 = 0; iv1 = 0;
    cmp_all(0);
    cmp_all(1);

    // Saturation: 300 injected active cycles from cyc 5.
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    run_to(1, 5);
    for (int n = 0; n < 300; n++) begin
      en1 = 1;
      iv1 = 1;
      ib1 = 3'($urandom_range(0, 7));
      @(negedge clk);
    end
    en1 = 0; iv1 = 0;
    chk("sat_cnt", cnt1, 255);
    chk("sat_first", first1, 5);
    chk("sat_cyc", cyc1, 305);
    run_to(1, 400);
    chk("sat_done", done1, 1);
    en1 = 1;
    repeat (3) @(negedge clk);
    en1 = 0;
    chk("sat_hold_cyc", cyc1, 400);
    chk("sat_hold_cnt", cnt1, 255);
    cmp_all(1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
